// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of an 8K x 1 simple-dual-port BRAM.
// It also runs a full-memory clear sequence and routes read returns back to their owner.
module bram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int READ_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_req,
  input  logic              i_a_wr,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic              i_a_di,
  output logic              o_a_gnt,
  output logic              o_a_rvalid,
  output logic              o_a_do,
  input  logic              i_b_req,
  input  logic              i_b_wr,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic              i_b_di,
  output logic              o_b_gnt,
  output logic              o_b_rvalid,
  output logic              o_b_do,
  input  logic              i_clr_start,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_wraddr,
  output logic              o_wren,
  output logic              o_we,
  output logic              o_di,
  output logic [ADDR_W-1:0] o_rdaddr,
  output logic              o_rden,
  output logic              o_regce,
  output logic              o_bram_rst,
  input  logic              i_do
);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(READ_LAT - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_wraddr;
  logic [ADDR_W-1:0]   r_rdaddr;
  logic                r_di;
  logic                r_prio_a;
  logic [READ_LAT-1:0] r_a_tag;
  logic [READ_LAT-1:0] r_b_tag;

  logic              w_busy;
  logic              w_clearing;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_sel_wr;
  logic              w_sel_di;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_wren;
  logic              w_rden;
  logic              w_di;
  logic [ADDR_W-1:0] w_wraddr;
  logic [ADDR_W-1:0] w_rdaddr;
  logic              w_a_rd;
  logic              w_b_rd;

  assign w_busy     = (r_state != IDLE);
  assign w_clearing = (r_state == CLEAR);

  // Grants are gated by reset so every grant-derived output is 0 while reset is held.
  assign w_a_gnt = i_rst_n & ~w_busy & i_a_req & (~i_b_req | r_prio_a);
  assign w_b_gnt = i_rst_n & ~w_busy & i_b_req & ~w_a_gnt;

  assign w_sel_wr   = w_a_gnt ? i_a_wr   : i_b_wr;
  assign w_sel_di   = w_a_gnt ? i_a_di   : i_b_di;
  assign w_sel_addr = w_a_gnt ? i_a_addr : i_b_addr;

  assign w_a_rd = w_a_gnt & ~i_a_wr;
  assign w_b_rd = w_b_gnt & ~i_b_wr;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_wren   = 1'b0;
    w_rden   = 1'b0;
    w_di     = r_di;
    w_wraddr = r_wraddr;
    w_rdaddr = r_rdaddr;
    if (w_clearing) begin
      w_wren   = 1'b1;
      w_wraddr = r_cnt;
      w_di     = 1'b0;
    end else if (w_a_gnt || w_b_gnt) begin
      if (w_sel_wr) begin
        w_wren   = 1'b1;
        w_wraddr = w_sel_addr;
        w_di     = w_sel_di;
      end else begin
        w_rden   = 1'b1;
        w_rdaddr = w_sel_addr;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_wraddr <= '0;
      r_rdaddr <= '0;
      r_di     <= 1'b0;
      r_prio_a <= 1'b1;
      r_a_tag  <= '0;
      r_b_tag  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update sees the pre-edge values.
      case (r_state)
        IDLE: begin
          if (i_clr_start) r_state <= CLEAR;
        end
        CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (&r_cnt) r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_cnt == DRAIN_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_a_gnt)      r_prio_a <= 1'b0;
      else if (w_b_gnt) r_prio_a <= 1'b1;

      if (w_wren) begin
        r_wraddr <= w_wraddr;
        r_di     <= w_di;
      end
      if (w_rden) r_rdaddr <= w_rdaddr;

      // Owner tags ride alongside the BRAM read latency and keep shifting through a clear.
      for (int i = READ_LAT - 1; i > 0; i--) begin
        r_a_tag[i] <= r_a_tag[i-1];
        r_b_tag[i] <= r_b_tag[i-1];
      end
      r_a_tag[0] <= w_a_rd;
      r_b_tag[0] <= w_b_rd;
    end
  end

  assign o_a_gnt    = w_a_gnt;
  assign o_b_gnt    = w_b_gnt;
  assign o_a_rvalid = r_a_tag[READ_LAT-1];
  assign o_b_rvalid = r_b_tag[READ_LAT-1];
  assign o_a_do     = r_a_tag[READ_LAT-1] & i_do;
  assign o_b_do     = r_b_tag[READ_LAT-1] & i_do;
  assign o_busy     = w_busy;
  assign o_wraddr   = w_wraddr;
  assign o_wren     = w_wren;
  assign o_we       = w_wren;
  assign o_di       = w_di;
  assign o_rdaddr   = w_rdaddr;
  assign o_rden     = w_rden;
  assign o_regce    = i_rst_n;
  assign o_bram_rst = ~i_rst_n;

endmodule
